// File: rtl/neuron_mac_seq.sv
// Sequential neuron: one Q-format a*w MAC per accepted beat, bias + saturate + activation after N_IN beats.
// Result registered one cycle after the last beat; in_ready drops until the result is taken; en=0 freezes everything.
module neuron_mac_seq #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24,
  parameter int N_IN  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] w,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       act_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             sat
);

  localparam int ACC_W = 2*WIDTH + $clog2(N_IN+1);
  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN-1);
  localparam logic signed [ACC_W-1:0] S_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] S_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) << FBITS;
  localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

  typedef enum logic [1:0] {S_ACC, S_FIN, S_OUT} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic signed [ACC_W-1:0]   acc;
  logic [WIDTH-1:0]          b_q;
  logic [1:0]                mode_q;

  logic signed [2*WIDTH-1:0] a_ext, w_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext, b_ext, sum, s_full;
  logic signed [WIDTH-1:0]   s_sat, y_next;
  logic                      clip;

  assign in_ready = en && (state == S_ACC);

  always_comb begin
    a_ext    = {{WIDTH{a[WIDTH-1]}}, a};
    w_ext    = {{WIDTH{w[WIDTH-1]}}, w};
    prod     = a_ext * w_ext;
    prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

    // Bias is aligned to the 2*FBITS product scale before the single floor shift.
    b_ext  = {{(ACC_W-WIDTH){b_q[WIDTH-1]}}, b_q};
    sum    = acc + (b_ext <<< FBITS);
    s_full = sum >>> FBITS;

    clip  = 1'b0;
    s_sat = s_full[WIDTH-1:0];
    if (s_full > S_MAX) begin
      clip  = 1'b1;
      s_sat = S_MAX[WIDTH-1:0];
    end else if (s_full < S_MIN) begin
      clip  = 1'b1;
      s_sat = S_MIN[WIDTH-1:0];
    end

    y_next = s_sat;
    case (mode_q)
      2'd1: if (s_sat[WIDTH-1]) y_next = '0;
      2'd2: begin
        if (s_sat > ONE)          y_next = ONE;
        else if (s_sat < NEG_ONE) y_next = NEG_ONE;
      end
      default: y_next = s_sat;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACC;
      cnt       <= '0;
      acc       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      sat       <= 1'b0;
    end else if (en) begin
      case (state)
        S_ACC: begin
          if (in_valid) begin
            acc <= acc + prod_ext;
            if (cnt == LAST) begin
              cnt    <= '0;
              b_q    <= b;
              mode_q <= act_mode;
              state  <= S_FIN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_FIN: begin
          y         <= y_next;
          sat       <= clip;
          out_valid <= 1'b1;
          acc       <= '0;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_ACC;
          end
        end
        default: state <= S_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq (WIDTH=32, FBITS=24, N_IN=3, 1.0 = 0x01000000).
module tb_neuron_mac_seq;

  logic        clk = 1'b0;
  logic        rst, en, in_valid, in_ready, out_valid, out_ready, sat;
  logic [31:0] a, w, b, y;
  logic [1:0]  act_mode;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  localparam logic [31:0] P1   = 32'h0100_0000;
  localparam logic [31:0] P2   = 32'h0200_0000;
  localparam logic [31:0] M1   = 32'hFF00_0000;
  localparam logic [31:0] PH   = 32'h0080_0000;
  localparam logic [31:0] PQ   = 32'h0040_0000;
  localparam logic [31:0] MH   = 32'hFF80_0000;
  localparam logic [31:0] BIG  = 32'h7F00_0000;
  localparam logic [31:0] MNEG = 32'h8000_0000;

  neuron_mac_seq #(.WIDTH(32), .FBITS(24), .N_IN(3)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .w(w), .b(b), .act_mode(act_mode),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .sat(sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one beat from a negedge and returns just after the edge that accepts it.
  task automatic beat(input logic [31:0] av, input logic [31:0] wv,
                      input logic [31:0] bv, input logic [1:0] mv);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1; a = av; w = wv; b = bv; act_mode = mv;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [31:0] ey, input logic es);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    check({tag, "_y"}, y, ey);
    check({tag, "_sat"}, 32'(sat), 32'(es));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_taken"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_vec(input string tag,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] bv, input logic [1:0] mv,
                         input logic [31:0] ey, input logic es);
    beat(a0, w0, 32'h0, 2'd0);
    beat(a1, w1, 32'h0, 2'd0);
    beat(a2, w2, bv, mv);
    collect(tag, ey, es);
  endtask

  initial begin
    int t0, t1;
    logic [31:0] yh;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; w = '0; b = '0; act_mode = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Scenario 1 with explicit latency: products 0.5 + 0.5 - 0.5, plus bias 0.25.
    beat(P1, PH, 32'h0, 2'd0);
    beat(P2, PQ, 32'h0, 2'd0);
    beat(MH, P1, PQ, 2'd0);
    check("lat_fin_valid", 32'(out_valid), 32'd0);
    check("lat_fin_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    collect("s1", 32'h00C0_0000, 1'b0);

    run_vec("s1_mode3", P1, P2, MH, PH, PQ, P1, PQ, 2'd3, 32'h00C0_0000, 1'b0);
    run_vec("relu_neg", P1, P2, MH, PH, PQ, P1, M1, 2'd1, 32'h0000_0000, 1'b0);
    run_vec("relu_pos", P1, P2, MH, PH, PQ, P1, P1, 2'd1, 32'h0180_0000, 1'b0);
    run_vec("id_neg",   P1, P2, MH, PH, PQ, P1, M1, 2'd0, 32'hFF80_0000, 1'b0);
    run_vec("tanh_hi",  P1, P1, P1, P1, P1, P1, 32'h0, 2'd2, P1, 1'b0);
    run_vec("tanh_lo",  P1, P1, P1, M1, M1, M1, 32'h0, 2'd2, M1, 1'b0);
    run_vec("tanh_mid", P1, P2, MH, PH, PQ, P1, 32'h0, 2'd2, PH, 1'b0);
    run_vec("sat_pos",  BIG, BIG, BIG, BIG, BIG, BIG, 32'h0, 2'd0, 32'h7FFF_FFFF, 1'b1);
    run_vec("sat_neg",  MNEG, MNEG, MNEG, BIG, BIG, BIG, 32'h0, 2'd0, 32'h8000_0000, 1'b1);
    // -1 LSB * 0.5 floors to -1 LSB rather than truncating to 0.
    run_vec("floor", 32'hFFFF_FFFF, 32'h0, 32'h0, PH, 32'h0, 32'h0, 32'h0, 2'd0, 32'hFFFF_FFFF, 1'b0);

    // Scenario 5: result held while out_ready is low.
    beat(P1, PH, 32'h0, 2'd0);
    beat(P2, PQ, 32'h0, 2'd0);
    beat(MH, P1, PQ, 2'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_y", y, 32'h00C0_0000);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back with out_ready held high: one result every N_IN+2 cycles.
    out_ready = 1'b1;
    t0 = -1; t1 = -1;
    fork
      begin
        for (int v = 0; v < 2; v++) begin
          beat(P1, PH, 32'h0, 2'd0);
          beat(P2, PQ, 32'h0, 2'd0);
          beat(MH, P1, PQ, 2'd0);
        end
      end
      begin
        for (int k = 0; k < 40 && t1 < 0; k++) begin
          @(negedge clk);
          if (out_valid) begin
            check("b2b_y", y, 32'h00C0_0000);
            if (t0 < 0) t0 = cyc; else t1 = cyc;
          end
        end
      end
    join
    check("b2b_period", 32'(t1 - t0), 32'd5);
    @(negedge clk);
    out_ready = 1'b0;

    // Reset after two beats discards the partial vector.
    @(negedge clk);
    yh = y;
    check("pre_rst_y_nonzero", 32'(yh != 0), 32'd1);
    beat(BIG, BIG, 32'h0, 2'd0);
    beat(BIG, BIG, 32'h0, 2'd0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_y", y, 32'd0);
    run_vec("after_rst", P1, P2, MH, PH, PQ, P1, PQ, 2'd0, 32'h00C0_0000, 1'b0);

    // en low for 4 cycles mid-vector with a beat pending.
    beat(P1, PH, 32'h0, 2'd0);
    @(negedge clk);
    en = 1'b0; in_valid = 1'b1; a = P2; w = PQ;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("en0_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; en = 1'b1;
    beat(P2, PQ, 32'h0, 2'd0);
    beat(MH, P1, PQ, 2'd0);
    collect("en0_mid", 32'h00C0_0000, 1'b0);

    // en low for 4 cycles while in FIN, then while OUT with out_ready high.
    beat(P1, PH, 32'h0, 2'd0);
    beat(P2, PQ, 32'h0, 2'd0);
    beat(MH, P1, PQ, 2'd0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("en0_fin_valid", 32'(out_valid), 32'd0);
    end
    en = 1'b1;
    @(negedge clk);
    check("fin_resume_valid", 32'(out_valid), 32'd1);
    en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("en0_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b0; en = 1'b1;
    collect("en0_fin", 32'h00C0_0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
